// File: rtl/time_entry_if.sv
// Keypad time-entry bus: controller/keypad inputs and the counter-chain load outputs.
interface time_entry_if;
    logic       en;
    logic [9:0] keypad;
    logic       start;
    logic [3:0] ones_data;
    logic [3:0] tens_data;
    logic [3:0] mins_data;
    logic       loadn;
    logic       key_strobe;

    modport master (
        output en, keypad, start,
        input  ones_data, tens_data, mins_data, loadn, key_strobe
    );

    modport slave (
        input  en, keypad, start,
        output ones_data, tens_data, mins_data, loadn, key_strobe
    );
endinterface

// File: rtl/time_entry_keypad.sv
// Debounced one-hot keypad entry into a 3-digit time buffer with a one-cycle loadn pulse.
// Optional TIME_ENTRY_CLAMP_EN: tens digit presented as min(tens,5) while loadn is low.
module time_entry_keypad #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic         clock,
    input logic         clearn,
    time_entry_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, LOAD} state_t;

    localparam logic [4:0] DB_LAST = 5'(DEBOUNCE_CYCLES);

    function automatic logic is_onehot(input logic [9:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n == 4'd1;
    endfunction

    function automatic logic [3:0] key_digit(input logic [9:0] k);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                d = 4'(i);
            end
        end
        return d;
    endfunction

`ifdef TIME_ENTRY_CLAMP_EN
    function automatic logic [3:0] sat_tens(input logic [3:0] t);
        return (t > 4'd5) ? 4'd5 : t;
    endfunction
`endif

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [4:0] cnt_inc;
    logic [9:0] code, code_n;
    logic [3:0] ones, ones_n;
    logic [3:0] tens, tens_n;
    logic [3:0] mins, mins_n;
    logic [3:0] tens_out, tens_out_n;
    logic       loadn_q, loadn_n;
    logic       strobe_q, strobe_n;
    logic       key_valid;
    logic       shift;

    assign key_valid = is_onehot(bus.keypad);
    assign cnt_inc   = {1'b0, cnt} + 5'd1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code;
        ones_n  = ones;
        tens_n  = tens;
        mins_n  = mins;
        shift   = 1'b0;

        if (!bus.en) begin
            // Timer running: entry frozen, digits kept for the display path.
            state_n = IDLE;
            cnt_n   = 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_valid) begin
                        code_n = bus.keypad;
                        if (DB_LAST == 5'd1) begin
                            shift   = 1'b1;
                            state_n = HELD;
                            cnt_n   = 4'd0;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = 4'd1;
                        end
                    end else if (bus.start && bus.keypad == 10'd0) begin
                        state_n = LOAD;
                    end
                end
                DEBOUNCE: begin
                    if (bus.keypad == code) begin
                        if (cnt_inc == DB_LAST) begin
                            shift   = 1'b1;
                            state_n = HELD;
                            cnt_n   = 4'd0;
                        end else begin
                            cnt_n = cnt_inc[3:0];
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = 4'd0;
                    end
                end
                HELD: begin
                    if (bus.keypad == 10'd0) begin
                        state_n = IDLE;
                    end
                end
                LOAD: begin
                    ones_n  = 4'd0;
                    tens_n  = 4'd0;
                    mins_n  = 4'd0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        // The accepted key is still on the keypad lines at the shift edge.
        if (shift) begin
            mins_n = tens;
            tens_n = ones;
            ones_n = key_digit(bus.keypad);
        end

        loadn_n  = (state_n != LOAD);
        strobe_n = shift;
`ifdef TIME_ENTRY_CLAMP_EN
        tens_out_n = (state_n == LOAD) ? sat_tens(tens_n) : tens_n;
`else
        tens_out_n = tens_n;
`endif
    end

    always_ff @(posedge clock) begin
        if (!clearn) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            code     <= 10'd0;
            ones     <= 4'd0;
            tens     <= 4'd0;
            mins     <= 4'd0;
            tens_out <= 4'd0;
            loadn_q  <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            code     <= code_n;
            ones     <= ones_n;
            tens     <= tens_n;
            mins     <= mins_n;
            tens_out <= tens_out_n;
            loadn_q  <= loadn_n;
            strobe_q <= strobe_n;
        end
    end

    assign bus.ones_data  = ones;
    assign bus.tens_data  = tens_out;
    assign bus.mins_data  = mins;
    assign bus.loadn      = loadn_q;
    assign bus.key_strobe = strobe_q;

endmodule

// File: tb/tb_time_entry_keypad.sv
// Bench for time_entry_keypad: directed vector table, hand sequences, and randomized model check.
module tb_time_entry_keypad;

    localparam int DB = 4;

    logic clock;
    logic clearn;
    time_entry_if bus();

    time_entry_keypad #(.DEBOUNCE_CYCLES(DB)) dut (
        .clock  (clock),
        .clearn (clearn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] kp;
        logic       start;
        logic       en;
        logic       clearn;
        logic [3:0] ones;
        logic [3:0] tens;
        logic [3:0] mins;
        logic       loadn;
        logic       strobe;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

`ifdef TIME_ENTRY_CLAMP_EN
    localparam logic [3:0] CLAMPED_8 = 4'd5;
`else
    localparam logic [3:0] CLAMPED_8 = 4'd8;
`endif

    function automatic logic [9:0] k(input int d);
        return 10'(1 << d);
    endfunction

    task automatic add_row(input logic [9:0] kp, input logic st, input logic e, input logic cn,
                           input int o, input int t, input int m, input logic ld, input logic sb);
        vec_t v;
        v.kp = kp; v.start = st; v.en = e; v.clearn = cn;
        v.ones = 4'(o); v.tens = 4'(t); v.mins = 4'(m); v.loadn = ld; v.strobe = sb;
        vecs.push_back(v);
    endtask

    // Key held DB edges then released one edge; previous digits (o,t,m) shift up.
    task automatic add_key(input int d, input int o, input int t, input int m);
        for (int i = 0; i < DB - 1; i++) add_row(k(d), 0, 1, 1, o, t, m, 1, 0);
        add_row(k(d), 0, 1, 1, d, o, t, 1, 1);
        add_row(10'd0, 0, 1, 1, d, o, t, 1, 0);
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ones=%0d tens=%0d mins=%0d loadn=%0b strobe=%0b, expected ones=%0d tens=%0d mins=%0d loadn=%0b strobe=%0b",
                     name, act[13:10], act[9:6], act[5:2], act[1], act[0],
                     exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [13:0] outs();
        return {bus.ones_data, bus.tens_data, bus.mins_data, bus.loadn, bus.key_strobe};
    endfunction

    task automatic step(input logic [9:0] kp, input logic st, input logic e, input logic cn);
        bus.keypad = kp;
        bus.start  = st;
        bus.en     = e;
        clearn     = cn;
        @(posedge clock);
        #1;
    endtask

    // Reference model: entered time kept as a decimal number 0..999.
    int   m_total;
    int   m_run;
    logic [9:0] m_key;
    bit   m_latched, m_loading, m_strobe;

    task automatic model_edge(input logic [9:0] kp, input logic st, input logic e, input logic cn);
        if (!cn) begin
            m_total = 0; m_run = 0; m_latched = 0; m_loading = 0; m_strobe = 0;
        end else if (!e) begin
            m_run = 0; m_latched = 0; m_loading = 0; m_strobe = 0;
        end else if (m_loading) begin
            m_total = 0; m_loading = 0; m_strobe = 0;
        end else if (m_latched) begin
            m_strobe = 0;
            if (kp == 10'd0) m_latched = 0;
        end else begin
            m_strobe = 0;
            if (m_run > 0 && kp != m_key) begin
                m_run = 0;
            end else if (m_run > 0 || $countones(kp) == 1) begin
                if (m_run == 0) m_key = kp;
                m_run++;
                if (m_run == DB) begin
                    m_total   = (m_total * 10 + $clog2(int'(kp))) % 1000;
                    m_strobe  = 1;
                    m_latched = 1;
                    m_run     = 0;
                end
            end else if (st && kp == 10'd0) begin
                m_loading = 1;
            end
        end
    endtask

    function automatic logic [13:0] model_outs();
        int t;
        t = (m_total / 10) % 10;
`ifdef TIME_ENTRY_CLAMP_EN
        if (m_loading && t > 5) t = 5;
`endif
        return {4'(m_total % 10), 4'(t), 4'(m_total / 100), !m_loading, m_strobe};
    endfunction

    initial begin
        logic [9:0] kp;
        logic st, e, cn;
        int r;

        bus.keypad = '0; bus.start = 0; bus.en = 1; clearn = 0;

        add_row(10'd0, 0, 1, 0, 0, 0, 0, 1, 0);
        // Reset in the middle of a debounce.
        add_row(k(7), 0, 1, 1, 0, 0, 0, 1, 0);
        add_row(k(7), 0, 1, 1, 0, 0, 0, 1, 0);
        add_row(10'd0, 0, 1, 0, 0, 0, 0, 1, 0);
        add_row(10'd0, 0, 1, 1, 0, 0, 0, 1, 0);
        add_key(1, 0, 0, 0);
        add_key(3, 1, 0, 0);
        add_key(0, 3, 1, 0);
        add_row(10'd0, 1, 1, 1, 0, 3, 1, 0, 0);
        add_row(10'd0, 0, 1, 1, 0, 0, 0, 1, 0);
        // Bounce, then an invalid two-bit pattern.
        for (int i = 0; i < 3; i++) add_row(k(5), 0, 1, 1, 0, 0, 0, 1, 0);
        add_row(10'd0, 0, 1, 1, 0, 0, 0, 1, 0);
        add_key(5, 0, 0, 0);
        for (int i = 0; i < 10; i++) add_row(10'h003, 0, 1, 1, 5, 0, 0, 1, 0);
        add_row(10'd0, 1, 1, 1, 5, 0, 0, 0, 0);
        add_row(10'd0, 0, 1, 1, 0, 0, 0, 1, 0);
        add_key(2, 0, 0, 0);
        add_key(4, 2, 0, 0);
        add_key(5, 4, 2, 0);
        add_row(10'd0, 1, 1, 1, 5, 4, 2, 0, 0);
        add_row(10'd0, 0, 1, 1, 0, 0, 0, 1, 0);
        add_key(0, 0, 0, 0);
        add_key(8, 0, 0, 0);
        add_key(0, 8, 0, 0);
        add_row(10'd0, 1, 1, 1, 0, int'(CLAMPED_8), 0, 0, 0);
        add_row(10'd0, 0, 1, 1, 0, 0, 0, 1, 0);
        // en drop mid-debounce with start high, then resume; key beats start.
        add_row(k(7), 0, 1, 1, 0, 0, 0, 1, 0);
        add_row(k(7), 0, 1, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) add_row(k(7), 1, 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < DB - 1; i++) add_row(k(7), 1, 1, 1, 0, 0, 0, 1, 0);
        add_row(k(7), 1, 1, 1, 7, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) add_row(k(7), 1, 1, 1, 7, 0, 0, 1, 0);
        add_row(10'd0, 0, 1, 1, 7, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].kp, vecs[i].start, vecs[i].en, vecs[i].clearn);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].ones, vecs[i].tens, vecs[i].mins, vecs[i].loadn, vecs[i].strobe});
        end

        // Held start: a load pulse every other cycle, first one carrying the old digits.
        for (int i = 0; i < 6; i++) begin
            step(10'd0, 1, 1, 1);
            check($sformatf("held_start%0d", i), outs(),
                  {(i == 0) ? 4'd7 : 4'd0, 4'd0, 4'd0, (i % 2) == 1, 1'b0});
        end
        step(10'd0, 0, 1, 1);
        check("held_start_end", outs(), {4'd0, 4'd0, 4'd0, 1'b1, 1'b0});

        // Long press: one strobe only, no auto-repeat.
        for (int i = 0; i < 12; i++) begin
            step(k(9), 0, 1, 1);
            check($sformatf("long_press%0d", i), outs(),
                  {(i >= DB - 1) ? 4'd9 : 4'd0, 4'd0, 4'd0, 1'b1, i == DB - 1});
        end
        step(10'd0, 0, 1, 1);

        // Randomized run against the reference model.
        step(10'd0, 0, 1, 0);
        model_edge(10'd0, 0, 1, 0);
        check("rand_reset", outs(), model_outs());
        kp = 10'd0;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r >= 70 && r < 85) kp = 10'd0;
            else if (r >= 85 && r < 97) kp = k(int'($urandom_range(0, 9)));
            else if (r >= 97) kp = 10'($urandom);
            st = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 19) != 0);
            cn = ($urandom_range(0, 59) != 0);
            model_edge(kp, st, e, cn);
            step(kp, st, e, cn);
            check($sformatf("rand%0d", c), outs(), model_outs());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_entry_keypad.md
# time_entry_keypad

Keypad time-entry stage for the microwave timer: debounces a one-hot 10-key keypad and shifts accepted digits into a 3-digit buffer (minutes, seconds-tens, seconds-units). On a start request it presents the buffered digits on `data` buses and issues a one-cycle active-low `loadn` pulse. That pulse parallel-loads the downstream down-counter chain (units mod-10, tens mod-6, minutes). It sits directly upstream of those counters and drives their `data`/`loadn` inputs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4 — consecutive identical samples required to accept a key; legal range 1–15.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clearn  in  1  reset, synchronous, active-low.
- en  in  1  entry enable from controller; high = idle/programming allowed, low = timer running.
- keypad  in  10  one-hot key lines, bit k = digit k, active-high, already synchronized upstream.
- start  in  1  load request, level-sensitive, active-high.
- ones_data  out  4  seconds-units digit for units counter `data`.
- tens_data  out  4  seconds-tens digit for tens counter `data`.
- mins_data  out  4  minutes digit for minutes counter `data`.
- loadn  out  1  active-low load pulse to all three counters.
- key_strobe  out  1  one-cycle high pulse on each accepted digit.

## Operation
- Reset (clearn=0 at an edge): state=IDLE, debounce count=0, all digits=0, loadn=1, key_strobe=0. This also applies mid-debounce or mid-LOAD.
- Key valid: exactly one keypad bit set. Zero bits or more than one bit are not valid.
- State machine:
  - IDLE:
    - valid key and en=1 → DEBOUNCE; capture the code; count=1.
    - start=1, keypad=0, en=1 → LOAD.
    - If both a key and start are present, the key wins and start is ignored.
  - DEBOUNCE:
    - Each edge: if keypad equals the captured code, count+1; otherwise → IDLE and count=0.
    - When count reaches DEBOUNCE_CYCLES: shift mins←tens, tens←ones, ones←digit; pulse key_strobe; go to HELD.
    - With DEBOUNCE_CYCLES=1 the shift happens on the first sample, and IDLE goes directly to HELD.
  - HELD: remain until keypad=0 for one edge, then → IDLE. This gives no auto-repeat. start is ignored in HELD.
  - LOAD: loadn=0 for exactly one cycle with digits stable. On the following edge all digits clear to 0, loadn=1, → IDLE.
- en=0 at any edge: force IDLE (LOAD included), clear count, hold digits, loadn=1, ignore keypad and start.
- Digits are stored modulo nothing: values 0–9 only. Minutes overflow on the 4th key: the old minutes digit is discarded.
- An invalid keypad pattern mid-DEBOUNCE aborts the debounce without shifting.

## Timing
- Output reset values: ones/tens/mins_data=0, loadn=1, key_strobe=0.
- Key latency:
  - Key held stable from before edge 1 → shift and key_strobe high after edge DEBOUNCE_CYCLES.
  - With the default 4, the digit is visible after the 4th edge.
- Start latency: start high before edge 1 in IDLE → loadn low after edge 1, high again after edge 2, digits zero after edge 2.
- A start held high across LOAD re-arms only after it is seen in IDLE. A held start therefore produces a loadn pulse every 2 cycles with digits 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- TIME_ENTRY_CLAMP_EN defined:
  - During LOAD, tens_data is presented as min(tens,5), and the stored value is unchanged until the clear.
  - Between loads, the display path sees the raw digit.
- Undefined: tens_data is presented raw (6–9 possible). A downstream mod-6 counter then counts down from that value before wrapping to 5.

## Test plan
- Reset mid-DEBOUNCE: key 7 held 2 edges, then clearn=0 for one edge → all digits 0, loadn=1, no key_strobe ever seen.
- Entry 1,3,0 (each held 4 edges, released 1 edge) → mins=1, tens=3, ones=0; key_strobe pulses exactly 3 times.
- Bounce: key 5 for 3 edges, keypad=0 for 1 edge, key 5 for 4 edges → exactly one shift with ones=5. Two-bit pattern 0x003 held 10 edges → no shift.
- Start after entry 2,4,5: one-cycle loadn=0 with mins=2, tens=4, ones=5. Next cycle: loadn=1 and all digits 0.
- Clamp: enter 0,8,0 then start:
  - with TIME_ENTRY_CLAMP_EN → tens_data=5 while loadn=0;
  - without → tens_data=8.
- en=0 during DEBOUNCE and with start=1 → no shift, no loadn pulse, digits held. Raising en back to 1 resumes from IDLE.
